toggle_handshake_sender: RTL and testbench
==========================================

Name: toggle_handshake_sender

Overview:
- Source-side half of the toggle-based clock-domain crossing used between the UART domain and the slow FIFO domain.
- Accepts one data word per valid/ready handshake and latches it into a stable holding register.
- Signals the word by inverting a level toggle that the destination-side synchronizer turns into a write pulse.
- Blocks further transfers until the destination's returned ack toggle, synchronized in this block, matches the request toggle.

Parameters:
- DATA_WIDTH, 8: width of the data word carried across the crossing.
- SYNC_STAGES, 2: number of flip-flops in the ack_toggle synchronizer; legal values are 2 to 4.
- TIMEOUT_CYCLES, 1024: ack wait limit in clk cycles; used only when ACK_TIMEOUT_EN is defined; must be at least 2.

Ports:
- clk  input  1  source-domain clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a data word is offered.
- in_data  input  DATA_WIDTH  word to transfer.
- in_ready  output  1  block can accept a word; high only in IDLE.
- data_out  output  DATA_WIDTH  holding register, sampled by the destination domain.
- toggle_out  output  1  request toggle to the destination synchronizer.
- ack_toggle  input  1  returned toggle from the destination; asynchronous to clk.
- done  output  1  one-cycle pulse when the ack matches.
- overrun  output  1  sticky flag: in_valid was seen while in_ready was low.
- timeout  output  1  one-cycle pulse when the ack wait expires; tied 0 without ACK_TIMEOUT_EN.

Behaviour:
- Reset: synchronous and active-high, sampled on the rising edge of clk.
  - Values after reset: state=IDLE, toggle_out=0, data_out=0, done=0, overrun=0, timeout=0, all synchronizer flops=0, timeout counter=0.
  - in_ready is 1 in the first cycle after reset.
- ack_toggle passes through SYNC_STAGES flops; ack_s is the last stage. Only ack_s is used by the logic.
- in_ready is a combinational decode of state==IDLE.
- IDLE:
  - Accept when in_valid && in_ready. On that edge: data_out<=in_data, toggle_out<=~toggle_out, state<=WAIT_ACK.
  - data_out and toggle_out change in the same cycle, and data_out is never updated without a toggle.
  - Latency: toggle_out and data_out are visible one clk after the accepting edge; in_ready drops in that same cycle.
- WAIT_ACK:
  - data_out and toggle_out hold; in_ready=0.
  - When ack_s==toggle_out: state<=IDLE and done=1 for exactly one cycle, registered and coincident with in_ready returning to 1.
  - A new word may be accepted in the first IDLE cycle, so back-to-back transfers are allowed.
- Minimum transfer period is 1 accept cycle plus the ack round trip plus 1 cycle.
- overrun is set on any cycle with in_valid=1 && in_ready=0. It stays set until rst. The offered word is dropped and never latched.
- Simultaneous cases:
  - ack_s matching on the same cycle in_valid is asserted (state still WAIT_ACK, in_ready=0): the word is not accepted and overrun is set. The upstream must hold in_valid until in_ready is seen.
- ack_s changing while the block is in IDLE: ignored, with no state change.
- Reset mid-transfer: toggle_out returns to 0 and the pending word is abandoned. Both crossing halves must be reset together, otherwise the destination sees a spurious edge. This is a system requirement and is not checked here.
- Toggle polarity: toggle_out wraps naturally (0→1→0); no counter width issue.

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without an ack match.
  - When the count reaches TIMEOUT_CYCLES-1 with still no match: timeout pulses 1 for one cycle, state<=IDLE, toggle_out keeps its value, done stays 0.
  - An ack match on that same cycle takes priority: done=1 and timeout=0.
  - The next accepted word toggles from the current toggle_out value.
- When not defined: WAIT_ACK waits indefinitely, the counter is not built, and timeout is tied 0.

Test Plan:
- Reset, then in_valid=1 with in_data=0xA5 for one cycle → next cycle data_out=0xA5, toggle_out=1, in_ready=0. Loop ack_toggle=toggle_out, so with SYNC_STAGES=2 done pulses 3 cycles after the toggle and in_ready returns to 1.
- Send 0x11, 0x22, 0x33 with in_valid held until in_ready is seen, ack looped → toggle_out goes 1,0,1; done pulses 3 times; data_out matches each word while in WAIT_ACK; overrun=0.
- Send 0x5A with ack held at 0, and pulse in_valid with 0xFF during WAIT_ACK → overrun=1 and stays 1; data_out stays 0x5A.
- Reset asserted in WAIT_ACK (toggle_out=1) → next cycle toggle_out=0, data_out=0, in_ready=1, done=0. Overrun sticky bit cleared.
- With ACK_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack held at 0 → timeout pulses in the 8th WAIT_ACK cycle, state returns to IDLE, toggle_out stays 1. The next word drives toggle_out to 0.
- ack_toggle toggled while in IDLE → no done pulse, no state change, in_ready stays 1.

Source files
------------

// File: rtl/toggle_handshake_sender.sv
// Source half of a toggle-handshake CDC: latches a word, flips toggle_out, waits for the synchronized ack.
// Optional ack wait limit enabled by defining ACK_TIMEOUT_EN.
module toggle_handshake_sender #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  toggle_out,
  input  logic                  ack_toggle,
  output logic                  done,
  output logic                  overrun,
  output logic                  timeout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be between 2 and 4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_toggle};
    end
  end

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign in_ready = (state == IDLE);

`ifdef ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      toggle_out <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (in_valid && !in_ready) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_out   <= in_data;
            toggle_out <= ~toggle_out;
            wait_cnt   <= '0;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // an ack arriving on the last allowed cycle wins over the timeout
          if (ack_s == toggle_out) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      toggle_out <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_valid && !in_ready) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_out   <= in_data;
            toggle_out <= ~toggle_out;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s == toggle_out) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_toggle_handshake_sender.sv
// Directed bench for toggle_handshake_sender; timeout checks run only when ACK_TIMEOUT_EN is defined.
module tb_toggle_handshake_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] data_out;
  logic       toggle_out;
  logic       ack_toggle;
  logic       done;
  logic       overrun;
  logic       timeout;

  logic ack_loop;
  logic ack_force;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt;

  assign ack_toggle = ack_loop ? toggle_out : ack_force;

  toggle_handshake_sender #(
    .DATA_WIDTH    (8),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .toggle_out(toggle_out),
    .ack_toggle(ack_toggle),
    .done      (done),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int i;
    i = 0;
    while (!in_ready && i < 20) begin
      tick();
      i++;
    end
    if (!in_ready) check("send_ready_wait", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 20) begin
      tick();
      i++;
    end
    if (done) done_cnt++;
    else check("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ack_loop  = 1'b0;
    ack_force = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_toggle", toggle_out, 0);
    check("rst_data", data_out, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);

    // single transfer with loopback ack
    ack_loop = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("t1_data", data_out, 8'hA5);
    check("t1_toggle", toggle_out, 1);
    check("t1_in_ready", in_ready, 0);
    tick();
    check("t1_done_c1", done, 0);
    tick();
    check("t1_done_c2", done, 0);
    tick();
    check("t1_done_c3", done, 1);
    check("t1_ready_back", in_ready, 1);
    tick();
    check("t1_done_pulse", done, 0);

    // three back-to-back words
    do_reset();
    done_cnt = 0;
    send(8'h11);
    check("t2_data_11", data_out, 8'h11);
    check("t2_tog_11", toggle_out, 1);
    wait_done();
    send(8'h22);
    check("t2_data_22", data_out, 8'h22);
    check("t2_tog_22", toggle_out, 0);
    wait_done();
    send(8'h33);
    check("t2_data_33", data_out, 8'h33);
    check("t2_tog_33", toggle_out, 1);
    wait_done();
    check("t2_done_count", done_cnt, 3);
    check("t2_overrun", overrun, 0);

    // in_valid on the same cycle the ack matches: dropped, overrun set
    do_reset();
    send(8'h44);
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    in_valid = 1'b0;
    check("sim_done", done, 1);
    check("sim_overrun", overrun, 1);
    check("sim_data", data_out, 8'h44);
    check("sim_toggle", toggle_out, 1);
    check("sim_ready", in_ready, 1);

    // overrun while waiting for an ack that never comes
    do_reset();
    ack_loop  = 1'b0;
    ack_force = 1'b0;
    send(8'h5A);
    tick();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_data", data_out, 8'h5A);
    check("ovr_in_ready", in_ready, 0);
    tick();
    tick();
    tick();
    check("ovr_sticky", overrun, 1);
    check("ovr_data_hold", data_out, 8'h5A);
    check("ovr_toggle_hold", toggle_out, 1);

    // reset in the middle of WAIT_ACK
    do_reset();
    check("mid_rst_toggle", toggle_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_overrun", overrun, 0);

    // ack movement in IDLE is ignored
    ack_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_ack_done", done, 0);
      check("idle_ack_ready", in_ready, 1);
    end
    ack_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_ack_back_done", done, 0);
    end

`ifdef ACK_TIMEOUT_EN
    do_reset();
    ack_force = 1'b0;
    send(8'h77);
    check("to_toggle", toggle_out, 1);
    for (int i = 0; i < 7; i++) begin
      check("to_not_yet", timeout, 0);
      check("to_waiting", in_ready, 0);
      tick();
    end
    check("to_last_wait", in_ready, 0);
    tick();
    check("to_pulse", timeout, 1);
    check("to_idle", in_ready, 1);
    check("to_toggle_kept", toggle_out, 1);
    check("to_no_done", done, 0);
    tick();
    check("to_pulse_end", timeout, 0);
    send(8'h78);
    check("to_next_toggle", toggle_out, 0);
    check("to_next_data", data_out, 8'h78);
`else
    check("no_to_tied", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
